// File: rtl/vga_timing_monitor_if.sv
// Pixel-stream bundle between a VGA timing source and the monitor.
// master drives pixEn/hSync/vSync/bright; slave returns lock status and x/y.
interface vga_timing_monitor_if;
  logic       pixEn;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       pixValid;
  logic [9:0] pixX;
  logic [9:0] pixY;
  logic       frameStart;
  logic       locked;
  logic       syncErr;
  logic [9:0] lineLen;
  logic [9:0] frameLines;

  modport master (
    output pixEn, hSync, vSync, bright,
    input  pixValid, pixX, pixY, frameStart,
    input  locked, syncErr, lineLen, frameLines
  );

  modport slave (
    input  pixEn, hSync, vSync, bright,
    output pixValid, pixX, pixY, frameStart,
    output locked, syncErr, lineLen, frameLines
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// VGA receive-side timing monitor: measures line/frame timing, locks, and
// regenerates visible x/y. Ports: clk, rst_n, vif (slave: syncs in, status out).
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input logic clk,
  input logic rst_n,
  vga_timing_monitor_if.slave vif
);

  localparam logic [9:0] H_TOT  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT  = 10'(V_TOTAL);
  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);
  localparam logic [9:0] SAT    = 10'h3ff;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] good_cnt_q, good_cnt_d;
  logic       h_prev_q, h_prev_d;
  logic       v_prev_q, v_prev_d;
  logic [9:0] h_per_cnt_q, h_per_cnt_d;
  logic [9:0] line_cnt_q, line_cnt_d;
  logic [9:0] line_len_q, line_len_d;
  logic [9:0] frame_lines_q, frame_lines_d;
  logic       line_err_q, line_err_d;
  logic [9:0] x_cnt_q, x_cnt_d;
  logic [9:0] y_cnt_q, y_cnt_d;
  logic       lhb_q, lhb_d;
  logic       pix_valid_q, pix_valid_d;
  logic [9:0] pix_x_q, pix_x_d;
  logic [9:0] pix_y_q, pix_y_d;
  logic       frame_start_q, frame_start_d;
  logic       sync_err_q, sync_err_d;

  logic       h_rise;
  logic       v_rise;
  logic       per_bad;
  logic       frame_ok;
  logic [9:0] new_fl;
  logic [9:0] cur_x;
  logic [2:0] good_inc;

  always_comb begin
    h_rise = vif.pixEn & vif.hSync & ~h_prev_q;
    v_rise = vif.pixEn & vif.vSync & ~v_prev_q;
    per_bad = h_rise & (h_per_cnt_q != H_TOT);
    // a coincident hRise closes the line that ends the old frame
    if (h_rise && line_cnt_q != SAT) begin
      new_fl = line_cnt_q + 10'd1;
    end else begin
      new_fl = line_cnt_q;
    end
    frame_ok = ~line_err_q & ~per_bad & (new_fl == V_TOT);
    cur_x = h_rise ? 10'd0 : x_cnt_q;
    good_inc = good_cnt_q + 3'd1;
  end

  always_comb begin
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    h_prev_d      = h_prev_q;
    v_prev_d      = v_prev_q;
    h_per_cnt_d   = h_per_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    line_err_d    = line_err_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    lhb_d         = lhb_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;

    if (vif.pixEn) begin
      h_prev_d = vif.hSync;
      v_prev_d = vif.vSync;

      if (h_rise) begin
        line_len_d  = h_per_cnt_q;
        h_per_cnt_d = 10'd1;
      end else if (h_per_cnt_q != SAT) begin
        h_per_cnt_d = h_per_cnt_q + 10'd1;
      end

      if (v_rise) begin
        frame_lines_d = new_fl;
        line_cnt_d    = 10'd0;
      end else if (h_rise && line_cnt_q != SAT) begin
        line_cnt_d = line_cnt_q + 10'd1;
      end

      if (v_rise) begin
        line_err_d = 1'b0;
      end else if (per_bad) begin
        line_err_d = 1'b1;
      end

      if (vif.bright) begin
        x_cnt_d = cur_x + 10'd1;
      end else if (h_rise) begin
        x_cnt_d = 10'd0;
      end

      // y only advances past lines that actually carried pixels
      if (v_rise) begin
        y_cnt_d = 10'd0;
        lhb_d   = 1'b0;
      end else if (h_rise) begin
        if (lhb_q) begin
          y_cnt_d = y_cnt_q + 10'd1;
        end
        lhb_d = vif.bright;
      end else if (vif.bright) begin
        lhb_d = 1'b1;
      end

      if (vif.bright && state_q == LOCKED) begin
        pix_valid_d = 1'b1;
        pix_x_d     = cur_x;
        pix_y_d     = y_cnt_q;
      end

      case (state_q)
        SEARCH: begin
          if (v_rise) begin
            state_d    = MEASURE;
            good_cnt_d = 3'd0;
          end
        end
        MEASURE: begin
          if (v_rise) begin
            if (frame_ok) begin
              good_cnt_d = good_inc;
              if (good_inc >= LOCK_N) begin
                state_d       = LOCKED;
                frame_start_d = 1'b1;
              end
            end else begin
              good_cnt_d = 3'd0;
            end
          end
        end
        LOCKED: begin
          if (per_bad || (v_rise && !frame_ok)) begin
            state_d    = MEASURE;
            good_cnt_d = 3'd0;
            sync_err_d = 1'b1;
          end else if (v_rise) begin
            frame_start_d = 1'b1;
          end
        end
        default: begin
          state_d    = SEARCH;
          good_cnt_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      good_cnt_q    <= 3'd0;
      h_prev_q      <= 1'b0;
      v_prev_q      <= 1'b0;
      h_per_cnt_q   <= 10'd0;
      line_cnt_q    <= 10'd0;
      line_len_q    <= 10'd0;
      frame_lines_q <= 10'd0;
      line_err_q    <= 1'b0;
      x_cnt_q       <= 10'd0;
      y_cnt_q       <= 10'd0;
      lhb_q         <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      h_prev_q      <= h_prev_d;
      v_prev_q      <= v_prev_d;
      h_per_cnt_q   <= h_per_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      line_err_q    <= line_err_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      lhb_q         <= lhb_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign vif.pixValid   = pix_valid_q;
  assign vif.pixX       = pix_x_q;
  assign vif.pixY       = pix_y_q;
  assign vif.frameStart = frame_start_q;
  assign vif.locked     = (state_q == LOCKED);
  assign vif.syncErr    = sync_err_q;
  assign vif.lineLen    = line_len_q;
  assign vif.frameLines = frame_lines_q;

endmodule
